pmc_dc_bus_initiator: RTL and testbench

Bus initiator for the PMC digital-configuration register space. It accepts queued read/write commands from a local controller, such as a test sequencer or a DMA-like config loader. It drives them one at a time onto the req/gnt/rvalid data bus that the PMC DC offset decoder responds on, and returns one response per command. An optional watchdog converts a stalled bus into an error response.

---
 rtl/pmc_dc_bus_initiator.sv | 232 +++++++++++++++++++++++
 tb/tb_pmc_dc_bus_initiator.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmc_dc_bus_initiator.sv
// pmc_dc_bus_initiator: queued req/gnt/rvalid bus master for the PMC DC register space.
// Optional watchdog built when PMC_DC_BUS_INITIATOR_TIMEOUT_EN is defined.
module pmc_dc_bus_initiator #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        req,
    input  logic        gnt,
    input  logic        rvalid,
    output logic [31:0] addr,
    output logic        we,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [AW:0]           wptr_q;
    logic [AW:0]           rptr_q;
    logic [31:0]           fifo_addr  [FIFO_DEPTH];
    logic [31:0]           fifo_wdata [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_we;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    logic [31:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_rdata_q;

    logic wd_expired;
    logic wd_fire;
    logic bus_done;

    assign wr_idx = wptr_q[AW-1:0];
    assign rd_idx = rptr_q[AW-1:0];
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wr_idx == rd_idx);
    assign push   = cmd_valid && !full;
    assign pop    = (state_q == S_IDLE) && !empty;

    // Command FIFO pointers: push and pop may both happen in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Command FIFO storage; the address is word-aligned on the way in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i]  <= '0;
                fifo_wdata[i] <= '0;
            end
            fifo_we <= '0;
        end else if (push) begin
            fifo_addr[wr_idx]  <= cmd_addr & 32'hFFFF_FFFC;
            fifo_wdata[wr_idx] <= cmd_wdata;
            fifo_we[wr_idx]    <= cmd_we;
        end
    end

`ifdef PMC_DC_BUS_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          rsp_err_q;

    assign wd_expired = (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts on every state change, counts time spent in REQ/WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (state_d != state_q) begin
            wd_cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // Error flag: set by a watchdog expiry, cleared by a normal completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (bus_done) begin
            rsp_err_q <= 1'b0;
        end else if (wd_fire) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign wd_expired = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // A grant or response in the expiry cycle takes priority over the watchdog.
    assign bus_done = (state_q == S_WAIT) && rvalid;
    assign wd_fire  = wd_expired &&
                      (((state_q == S_REQ) && !gnt) ||
                       ((state_q == S_WAIT) && !rvalid));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: one transaction outstanding at a time.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (gnt) begin
                    state_d = S_WAIT;
                end else if (wd_expired) begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (rvalid) begin
                    state_d = S_RESP;
                end else if (wd_expired) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: request during REQ, one-cycle response strobe in RESP.
    always_comb begin
        req       = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            S_REQ:   req       = 1'b1;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Bus address/control registers, loaded when the head command is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (pop) begin
            addr_q  <= fifo_addr[rd_idx];
            we_q    <= fifo_we[rd_idx];
            wdata_q <= fifo_wdata[rd_idx];
        end
    end

    // Response data: bus read data for reads, zero for writes and timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q <= '0;
        end else if (bus_done) begin
            rsp_rdata_q <= we_q ? 32'h0 : rdata;
        end else if (wd_fire) begin
            rsp_rdata_q <= '0;
        end
    end

    assign addr      = addr_q;
    assign we        = we_q;
    assign wdata     = wdata_q;
    assign be        = 4'hF;
    assign rsp_rdata = rsp_rdata_q;
    assign cmd_ready = !full;
    assign busy      = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_pmc_dc_bus_initiator.sv
// tb_pmc_dc_bus_initiator: directed and randomized checks of pmc_dc_bus_initiator.
// A memory-backed bus responder and an in-order response model predict results.
module tb_pmc_dc_bus_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        req;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;
    logic        busy;

    pmc_dc_bus_initiator #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .req       (req),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .addr      (addr),
        .we        (we),
        .be        (be),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
    } bus_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    bus_t        exp_bus [$];
    rsp_t        exp_rsp [$];
    logic [31:0] model_mem [int];
    logic [31:0] bus_mem [int];

    int n_cmp = 0;
    int n_err = 0;
    int push_cyc = 0;
    int rsp_cnt = 0;
    int req_run = 0;
    int last_req_len = 0;

    function automatic logic [31:0] dflt(input int k);
        return 32'hC0DE_0000 ^ (32'(k) * 32'h0001_0101);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- bus responder ----------------
    bit          gnt_hold = 1'b0;
    bit          rv_hold = 1'b0;
    bit          rand_mode = 1'b0;
    int          gnt_delay = 0;
    int          rnd_delay = 0;
    int          age = 0;
    bit          rv_pend = 1'b0;
    logic [31:0] rv_data = '0;

    task automatic bus_grant();
        bus_t b;
        int   k;
        chk("bus_cmd_expected", 32'(exp_bus.size() > 0), 1);
        chk("bus_be", 32'(be), 32'hF);
        if (exp_bus.size() > 0) begin
            b = exp_bus.pop_front();
            chk("bus_addr", addr, b.a);
            chk("bus_we", 32'(we), 32'(b.w));
            if (b.w) chk("bus_wdata", wdata, b.d);
        end
        k = int'(addr >> 2);
        if (we) begin
            bus_mem[k] = wdata;
            rv_data = $urandom;
        end else begin
            rv_data = bus_mem.exists(k) ? bus_mem[k] : dflt(k);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt = 1'b0;
            rvalid = 1'b0;
            rv_pend = 1'b0;
            age = 0;
        end else begin
            gnt = 1'b0;
            rvalid = 1'b0;
            rdata = $urandom;
            if (rv_pend) begin
                if (!rv_hold && !(rand_mode && $urandom_range(0, 2) == 0)) begin
                    rvalid = 1'b1;
                    rdata = rv_data;
                    rv_pend = 1'b0;
                end
            end else if (req) begin
                if (!gnt_hold && age >= (rand_mode ? rnd_delay : gnt_delay)) begin
                    gnt = 1'b1;
                    age = 0;
                    rnd_delay = $urandom_range(0, 3);
                    rv_pend = 1'b1;
                    bus_grant();
                end else begin
                    age++;
                end
            end else begin
                age = 0;
                if (rand_mode && $urandom_range(0, 3) == 0) begin
                    gnt = 1'b1;
                    rvalid = 1'b1;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    logic        prev_req = 1'b0;
    logic        prev_rsp = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        rsp_t r;
        if (rst_n) begin
            if (req && prev_req) chk("addr_stable", addr, prev_addr);
            if (rsp_valid) begin
                chk("rsp_one_cycle", 32'(prev_rsp), 0);
                chk("rsp_expected", 32'(exp_rsp.size() > 0), 1);
                if (exp_rsp.size() > 0) begin
                    r = exp_rsp.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.d);
                    chk("rsp_err", 32'(rsp_err), 32'(r.e));
                end
                rsp_cnt <= rsp_cnt + 1;
            end
        end
        if (req) begin
            req_run <= req_run + 1;
        end else if (prev_req) begin
            last_req_len <= req_run;
            req_run <= 0;
        end
        prev_req  <= req;
        prev_rsp  <= rsp_valid;
        prev_addr <= addr;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int waited);
        rsp_t r;
        bus_t b;
        int   k;
        cmd_valid = 1'b1;
        cmd_we = w;
        cmd_addr = a;
        cmd_wdata = d;
        waited = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("push_accept", 32'(cmd_ready), 1);
        k = int'(a >> 2);
        b.a = a & 32'hFFFF_FFFC;
        b.w = w;
        b.d = d;
        exp_bus.push_back(b);
        r.e = 1'b0;
        r.d = w ? 32'h0 : (model_mem.exists(k) ? model_mem[k] : dflt(k));
        if (w) model_mem[k] = d;
        exp_rsp.push_back(r);
        push_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_one(input bit w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int rl);
        int n;
        int wt;
        rl = 0;
        n = 0;
        push(w, a, d, wt);
        while (!rsp_valid && n < 300) begin
            if (req) rl++;
            @(negedge clk);
            n++;
        end
        chk("rsp_arrives", 32'(n < 300), 1);
        lat = cyc - push_cyc;
    endtask

    task automatic drain(input string tag, input int lim);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < lim), 1);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_req"}, 32'(req), 0);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_be"}, 32'(be), 32'hF);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        int rl;
        int wt;
        int base;
        rsp_t tmp;

        bus_mem[0] = 32'h1234_5678;
        model_mem[0] = 32'h1234_5678;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_one(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, lat, rl);
        chk("write_latency", 32'(lat), 4);
        chk("write_req_len", 32'(rl), 1);
        chk("write_rdata", rsp_rdata, 0);

        run_one(1'b0, 32'h0000_0003, 32'hAAAA_5555, lat, rl);
        chk("read_latency", 32'(lat), 4);
        chk("read_rdata", rsp_rdata, 32'h1234_5678);

        gnt_delay = 3;
        run_one(1'b0, 32'h0000_0010, 32'h0, lat, rl);
        chk("delay_latency", 32'(lat), 7);
        chk("delay_req_len", 32'(rl), 4);
        gnt_delay = 0;
        @(negedge clk);

        gnt_hold = 1'b1;
        base = rsp_cnt;
        push(1'b1, 32'h40, 32'hA0A0_0001, wt);
        chk("fill_wait0", 32'(wt), 0);
        push(1'b1, 32'h44, 32'hB0B0_0002, wt);
        chk("fill_wait1", 32'(wt), 0);
        push(1'b0, 32'h41, 32'h0, wt);
        chk("fill_wait2", 32'(wt), 0);
        push(1'b0, 32'h46, 32'h0, wt);
        chk("fill_wait3", 32'(wt), 0);
        push(1'b0, 32'h48, 32'h0, wt);
        chk("fill_wait4", 32'(wt), 0);
        chk("fill_ready_low", 32'(cmd_ready), 0);
        chk("fill_busy", 32'(busy), 1);
        @(negedge clk);
        chk("fill_ready_held", 32'(cmd_ready), 0);
        gnt_hold = 1'b0;
        drain("fill_drain", 200);
        chk("fill_rsp_count", 32'(rsp_cnt - base), 5);

`ifdef PMC_DC_BUS_INITIATOR_TIMEOUT_EN
        gnt_hold = 1'b1;
        push(1'b0, 32'h80, 32'h0, wt);
        lat = push_cyc;
        void'(exp_bus.pop_back());
        tmp = exp_rsp.pop_back();
        tmp.d = 32'h0;
        tmp.e = 1'b1;
        exp_rsp.push_back(tmp);
        push(1'b1, 32'h84, 32'h55AA_33CC, wt);
        rl = 0;
        while (!rsp_valid && rl < 100) begin
            @(negedge clk);
            rl++;
        end
        chk("tmo_latency", 32'(cyc - lat), 18);
        chk("tmo_err", 32'(rsp_err), 1);
        chk("tmo_rdata", rsp_rdata, 0);
        @(negedge clk);
        chk("tmo_req_len", 32'(last_req_len), 16);
        gnt_hold = 1'b0;
        drain("tmo_drain", 100);
        chk("tmo_next_err", 32'(rsp_err), 0);
`endif

        run_one(1'b0, 32'h0, 32'h0, lat, rl);
        chk("pre_reset_rdata", rsp_rdata, 32'h1234_5678);
        @(negedge clk);

        rv_hold = 1'b1;
        push(1'b0, 32'h08, 32'h0, wt);
        push(1'b0, 32'h0C, 32'h0, wt);
        push(1'b0, 32'h10, 32'h0, wt);
        @(negedge clk);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_req_low", 32'(req), 0);
        base = rsp_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("midreset");
        exp_rsp.delete();
        exp_bus.delete();
        rv_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_no_rsp", 32'(rsp_cnt - base), 0);
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_ready", 32'(cmd_ready), 1);

        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom, wt);
        end
        drain("rand_drain", 2000);
        rand_mode = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
